// File: rtl/sll_wide_iter_pkg.sv
// Shared ALU shift package: FSM states, default sizes and
// the shift-amount width helper.
package sll_wide_iter_pkg;

    localparam int unsigned DEF_WIDTH           = 32;
    localparam int unsigned DEF_SHIFT_PER_CYCLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int unsigned amt_width(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/sll_wide_iter_if.sv
// Request/result bundle of the iterative left shifter.
// master drives requests and consumes results; slave is the unit.
interface sll_wide_iter_if
    import sll_wide_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_high;
    logic [WIDTH-1:0] res_low;

    modport master (
        output start, a, b, out_ready,
        input  busy, out_valid, res_high, res_low
    );

    modport slave (
        input  start, a, b, out_ready,
        output busy, out_valid, res_high, res_low
    );

endinterface

// File: rtl/sll_wide_iter_step.sv
// Bounded shifter: moves acc left by min(rem, SHIFT_PER_CYCLE).
// Purely combinational so a right-shift variant can reuse the shape.
module sll_step
    import sll_wide_iter_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned SHIFT_PER_CYCLE = DEF_SHIFT_PER_CYCLE,
    parameter int unsigned AMT_W           = amt_width(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [AMT_W-1:0]   rem_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [AMT_W-1:0]   rem_o,
    output logic               last_o
);

    localparam logic [AMT_W-1:0] SPC = AMT_W'(SHIFT_PER_CYCLE);

    logic [AMT_W-1:0] step;

    assign step   = (rem_i < SPC) ? rem_i : SPC;
    assign acc_o  = acc_i << step;
    assign rem_o  = rem_i - step;
    assign last_o = (rem_o == '0);

endmodule

// File: rtl/sll_wide_iter.sv
// Multi-cycle SLL: {res_high,res_low} = {0,a} << b, a few bits per
// clock, result returned over a valid/ready handshake.
module sll_wide_iter
    import sll_wide_iter_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned SHIFT_PER_CYCLE = DEF_SHIFT_PER_CYCLE
) (
    input logic            clock,
    input logic            reset_n,
    sll_wide_iter_if.slave bus
);

    localparam int unsigned AMT_W = amt_width(WIDTH);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [AMT_W-1:0]     rem_q, rem_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic [AMT_W-1:0]     step_rem;
    logic                 step_last;

    logic                 oversize;
    logic [AMT_W-1:0]     amt;
    logic                 accept;

    // Amounts of 2*WIDTH or more flush everything out of the pair.
    if (WIDTH > AMT_W) begin : g_over
        assign oversize = |bus.b[WIDTH-1:AMT_W];
    end else begin : g_no_over
        assign oversize = 1'b0;
    end

    assign amt    = bus.b[AMT_W-1:0];
    assign accept = bus.start &&
                    ((state_q == IDLE) ||
                     ((state_q == DONE) && bus.out_ready));

    sll_step #(
        .WIDTH           (WIDTH),
        .SHIFT_PER_CYCLE (SHIFT_PER_CYCLE),
        .AMT_W           (AMT_W)
    ) u_step (
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .acc_o  (step_acc),
        .rem_o  (step_rem),
        .last_o (step_last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (!accept) state_d = IDLE;
            end
            SHIFT: begin
                acc_d = step_acc;
                rem_d = step_rem;
                if (step_last) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (oversize) begin
                acc_d   = '0;
                rem_d   = '0;
                state_d = DONE;
            end else begin
                acc_d   = {{WIDTH{1'b0}}, bus.a};
                rem_d   = amt;
                state_d = (amt == '0) ? DONE : SHIFT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.res_high  = acc_q[2*WIDTH-1:WIDTH];
    assign bus.res_low   = acc_q[WIDTH-1:0];

endmodule
